// File: rtl/lm32_dp_ram_pkg.sv
// Shared types and helpers for the lm32 byte-enable dual-port RAM.
// Holds the clear FSM encoding, collision-mode codes and lane-count derivation.
package lm32_dp_ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam int COLL_READ_OLD      = 0;
   localparam int COLL_WRITE_THROUGH = 1;

   function automatic int calc_nb(input int dw, input int bw);
      return dw / bw;
   endfunction

endpackage

// File: rtl/lm32_dp_ram_lane.sv
// One byte lane of the RAM: single write port, single read port with a
// registered read result that holds until the next accepted read.
module lm32_dp_ram_lane #(
   parameter int addr_width = 10,
   parameter int addr_depth = 1024,
   parameter int byte_width = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  we_i,
   input  logic [addr_width-1:0] waddr_i,
   input  logic [byte_width-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [addr_width-1:0] raddr_i,
   output logic [byte_width-1:0] rdata_o
);

   // Only the low index bits are needed; the top never passes an out-of-range address.
   localparam int IW = (addr_depth > 1) ? $clog2(addr_depth) : 1;

   logic [byte_width-1:0] mem_r [addr_depth];
   logic [byte_width-1:0] rdata_r;

   // Array write; contents are intentionally left unreset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_r[waddr_i[IW-1:0]] <= wdata_i;
      end
   end

   // Read register samples the pre-write word on a same-cycle collision.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_r <= '0;
      end else if (re_i) begin
         rdata_r <= mem_r[raddr_i[IW-1:0]];
      end
   end

   assign rdata_o = rdata_r;

endmodule

// File: rtl/lm32_dp_ram_be.sv
// Byte-enable simple dual-port RAM with clear engine, collision bypass and
// optional output register, built from byte-wide lanes.
module lm32_dp_ram_be
   import lm32_dp_ram_pkg::*;
#(
   parameter int addr_width     = 10,
   parameter int addr_depth     = 1024,
   parameter int data_width     = 32,
   parameter int byte_width     = 8,
   parameter int out_reg        = 0,
   parameter int collision_mode = 0
) (
   input  logic                                     clk_i,
   input  logic                                     rst_n_i,
   input  logic                                     clr_i,
   output logic                                     busy_o,
   input  logic                                     we_i,
   input  logic [calc_nb(data_width, byte_width)-1:0] be_i,
   input  logic [addr_width-1:0]                    waddr_i,
   input  logic [data_width-1:0]                    wdata_i,
   input  logic                                     re_i,
   input  logic [addr_width-1:0]                    raddr_i,
   output logic [data_width-1:0]                    rdata_o,
   output logic                                     rvalid_o
);

   localparam int NB = calc_nb(data_width, byte_width);
   localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(addr_depth - 1);
   localparam logic [addr_width-1:0] ONE_ADDR  = addr_width'(1);

   state_t                state_r, state_s;
   logic [addr_width-1:0] cnt_r, cnt_s;
   logic                  busy_s, w_in_s, r_in_s, rd_acc_s, coll_s;
   logic [NB-1:0]         lane_we_s, byp_mask_r;
   logic [addr_width-1:0] lane_waddr_s;
   logic [data_width-1:0] lane_wdata_s, lane_rdata_s, byp_data_r, rd1_s;
   logic                  oor_r, v1_r;

   assign busy_s = (state_r == ST_CLEAR);
   assign busy_o = busy_s;

   if (addr_depth == (32'd1 << addr_width)) begin : g_full_range
      assign w_in_s = 1'b1;
      assign r_in_s = 1'b1;
   end else begin : g_part_range
      localparam logic [addr_width:0] DEPTH_V = (addr_width + 1)'(addr_depth);
      assign w_in_s = ({1'b0, waddr_i} < DEPTH_V);
      assign r_in_s = ({1'b0, raddr_i} < DEPTH_V);
   end

   // FSM state and clear counter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= ST_CLEAR;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic: sweep every word in CLEAR, accept a clear request in IDLE.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_CLEAR: begin
            if (cnt_r == LAST_ADDR) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + ONE_ADDR;
            end
         end
         ST_IDLE: begin
            if (clr_i) begin
               state_s = ST_CLEAR;
               cnt_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_CLEAR;
            cnt_s   = '0;
         end
      endcase
   end

   // Write-port mux: the clear engine owns all lanes while busy.
   always_comb begin
      lane_waddr_s = waddr_i;
      lane_wdata_s = wdata_i;
      lane_we_s    = '0;
      if (busy_s) begin
         lane_waddr_s = cnt_r;
         lane_wdata_s = '0;
         lane_we_s    = '1;
      end else begin
         lane_we_s    = (we_i && w_in_s) ? be_i : '0;
      end
   end

   assign rd_acc_s = re_i && !busy_s;
   assign coll_s   = (collision_mode == COLL_WRITE_THROUGH) && we_i && w_in_s && r_in_s &&
                     (waddr_i == raddr_i);

   for (genvar k = 0; k < NB; k++) begin : g_lane
      lm32_dp_ram_lane #(
         .addr_width (addr_width),
         .addr_depth (addr_depth),
         .byte_width (byte_width)
      ) u_lane (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .we_i    (lane_we_s[k]),
         .waddr_i (lane_waddr_s),
         .wdata_i (lane_wdata_s[k*byte_width +: byte_width]),
         .re_i    (rd_acc_s && r_in_s),
         .raddr_i (raddr_i),
         .rdata_o (lane_rdata_s[k*byte_width +: byte_width])
      );
   end

   // Per-read tags: valid, out-of-range and write-through lanes; tags hold between reads.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1_r       <= 1'b0;
         oor_r      <= 1'b0;
         byp_mask_r <= '0;
         byp_data_r <= '0;
      end else begin
         v1_r <= rd_acc_s;
         if (rd_acc_s) begin
            oor_r      <= !r_in_s;
            byp_mask_r <= coll_s ? be_i : '0;
            byp_data_r <= wdata_i;
         end
      end
   end

   // Merge lane data with bypassed write data; out-of-range reads return zero.
   always_comb begin
      rd1_s = '0;
      for (int k = 0; k < NB; k++) begin
         if (oor_r) begin
            rd1_s[k*byte_width +: byte_width] = '0;
         end else if (byp_mask_r[k]) begin
            rd1_s[k*byte_width +: byte_width] = byp_data_r[k*byte_width +: byte_width];
         end else begin
            rd1_s[k*byte_width +: byte_width] = lane_rdata_s[k*byte_width +: byte_width];
         end
      end
   end

   if (out_reg != 0) begin : g_oreg
      logic                  v2_r;
      logic [data_width-1:0] d2_r;

      // Optional output stage; data only advances with a completing read.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            v2_r <= 1'b0;
            d2_r <= '0;
         end else begin
            v2_r <= v1_r;
            if (v1_r) begin
               d2_r <= rd1_s;
            end
         end
      end

      assign rvalid_o = v2_r;
      assign rdata_o  = d2_r;
   end else begin : g_direct
      assign rvalid_o = v1_r;
      assign rdata_o  = rd1_s;
   end

endmodule

// File: tb/tb_lm32_dp_ram_be.sv
// Scoreboard bench: two RAM instances (direct/read-old and registered/write-through)
// share stimulus; per-instance monitors pop expected words as rvalid_o pulses.
module tb_lm32_dp_ram_be;

   localparam int AW = 5, DEPTH = 16, DW = 32, BW = 8, NB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clr = 1'b0, we = 1'b0, re = 1'b0;
   logic [NB-1:0] be = '0;
   logic [AW-1:0] waddr = '0, raddr = '0;
   logic [DW-1:0] wdata = '0;
   logic          busy0, busy1, rv0, rv1;
   logic [DW-1:0] rd0, rd1;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   lm32_dp_ram_be #(.addr_width(AW), .addr_depth(DEPTH), .data_width(DW), .byte_width(BW),
                    .out_reg(0), .collision_mode(0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy0), .we_i(we), .be_i(be),
      .waddr_i(waddr), .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
      .rdata_o(rd0), .rvalid_o(rv0));

   lm32_dp_ram_be #(.addr_width(AW), .addr_depth(DEPTH), .data_width(DW), .byte_width(BW),
                    .out_reg(1), .collision_mode(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy1), .we_i(we), .be_i(be),
      .waddr_i(waddr), .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
      .rdata_o(rd1), .rvalid_o(rv1));

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the direct-output instance.
   always @(negedge clk) begin
      exp_t e;
      if (rv0) begin
         check("dut0 rvalid has pending read", 32'(q0.size() > 0), 32'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0 rdata", rd0, e.data);
            check("dut0 latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   // Monitor for the registered-output instance.
   always @(negedge clk) begin
      exp_t e;
      if (rv1) begin
         check("dut1 rvalid has pending read", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1 rdata", rd1, e.data);
            check("dut1 latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic op(input logic w, input logic [NB-1:0] b, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra,
                     input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic push);
      @(negedge clk);
      we = w; be = b; waddr = wa; wdata = wd; re = r; raddr = ra;
      if (push) begin
         q0.push_back('{e0, cyc + 1});
         q1.push_back('{e1, cyc + 2});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) op(1'b0, 4'b0000, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
      op(1'b1, b, a, d, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      op(1'b0, 4'b0000, 5'd0, 32'd0, 1'b1, a, e0, e1, 1'b1);
   endtask

   task automatic read_all_zero();
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), 32'd0, 32'd0);
      idle(3);
   endtask

   task automatic count_busy(input string tag);
      int n0 = 0;
      int n1 = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!busy0 && n0 == 0) n0 = i;
         if (!busy1 && n1 == 0) n1 = i;
      end
      check({tag, " dut0 busy cycles"}, 32'(n0), 32'd16);
      check({tag, " dut1 busy cycles"}, 32'(n1), 32'd16);
   endtask

   // Caller positions just after a rising edge; reset lands mid-cycle.
   task automatic reset_now(input string tag);
      #1;
      rst_n = 1'b0;
      clr = 1'b0; we = 1'b0; re = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      check({tag, " dut0 rvalid in reset"}, 32'(rv0), 32'd0);
      check({tag, " dut1 rvalid in reset"}, 32'(rv1), 32'd0);
      check({tag, " dut0 busy in reset"}, 32'(busy0), 32'd1);
      check({tag, " dut0 rdata in reset"}, rd0, 32'd0);
      check({tag, " dut1 rdata in reset"}, rd1, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(tag);
   endtask

   initial begin
      int n0;
      int n1;

      @(posedge clk);
      reset_now("por");
      read_all_zero();

      // Byte-lane merge.
      wr(5'd3, 32'hDEADBEEF, 4'b1111);
      wr(5'd3, 32'h000000AA, 4'b0001);
      rd(5'd3, 32'hDEADBEAA, 32'hDEADBEAA);

      // Same-address collision: read-old on dut0, write-through on dut1.
      wr(5'd5, 32'hFFFFFFFF, 4'b1111);
      op(1'b1, 4'b0011, 5'd5, 32'h12345678, 1'b1, 5'd5, 32'hFFFFFFFF, 32'hFFFF5678, 1'b1);
      rd(5'd5, 32'hFFFF5678, 32'hFFFF5678);

      // Back-to-back reads with distinct data.
      for (int i = 0; i < 8; i++) wr(AW'(i), 32'h11111111 * (i + 1), 4'b1111);
      for (int i = 0; i < 8; i++) rd(AW'(i), 32'h11111111 * (i + 1), 32'h11111111 * (i + 1));

      // Out-of-range write must not alias onto word 4; out-of-range read returns zero.
      wr(5'd20, 32'hCAFEF00D, 4'b1111);
      rd(5'd20, 32'd0, 32'd0);
      rd(5'd4, 32'h55555555, 32'h55555555);
      idle(4);
      check("dut0 rdata hold", rd0, 32'h55555555);
      check("dut1 rdata hold", rd1, 32'h55555555);

      // Clear request with port traffic during busy.
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr dut0 busy start", 32'(busy0), 32'd1);
      n0 = 0;
      n1 = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!busy0 && n0 == 0) n0 = i;
         if (!busy1 && n1 == 0) n1 = i;
         if (busy0 && busy1) begin
            we = 1'b1; be = 4'b1111; waddr = 5'd0; wdata = 32'hBAD0BAD0;
            re = 1'b1; raddr = 5'd3;
         end else begin
            we = 1'b0; re = 1'b0;
         end
      end
      check("clr dut0 busy cycles", 32'(n0), 32'd16);
      check("clr dut1 busy cycles", 32'(n1), 32'd16);
      read_all_zero();

      // Reset in the middle of a clear (counter at 7).
      wr(5'd9, 32'h12121212, 4'b1111);
      @(negedge clk);
      we = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (7) @(posedge clk);
      reset_now("midclear");
      read_all_zero();

      // Reset while a read is in flight.
      wr(5'd3, 32'h33333333, 4'b1111);
      @(negedge clk);
      we = 1'b0;
      re = 1'b1;
      raddr = 5'd3;
      @(posedge clk);
      reset_now("midread");

      idle(4);
      check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
      check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
